l2_port_arbiter: RTL and testbench

Shares the single L2 request port between `NUM_REQ` L1 miss controllers, one per core/L1 instance. Each controller presents its L2 read or write-back the same way it would to a private L2. The arbiter picks one winner per cycle in round-robin order and registers the winner onto the L2 port. It records the winner's ID in an in-order tag FIFO and routes each `l2_done` and its read data back to the requester that issued it. A `flush` input drains all outstanding L2 traffic before cache maintenance.

---
 rtl/l2_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port among NUM_REQ L1 miss controllers.
// Issue order is tracked in a tag FIFO so completions are routed back to their requesters.
module l2_port_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned OUT_DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_rw,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_stall,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [DATA_W-1:0]         resp_rdata,
   output logic                      l2_valid,
   output logic                      l2_rw,
   output logic [ADDR_W-1:0]         l2_addr,
   output logic [DATA_W-1:0]         l2_wdata,
   input  logic                      l2_stall,
   input  logic                      l2_done,
   input  logic [DATA_W-1:0]         l2_rdata,
   input  logic                      flush,
   output logic                      flush_done,
   output logic                      busy,
   output logic                      spurious_done
);

   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     fifo_q [OUT_DEPTH];
   logic [ID_W-1:0]     fifo_d [OUT_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                l2_valid_q, l2_valid_d;
   logic                l2_rw_q, l2_rw_d;
   logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
   logic [DATA_W-1:0]   l2_wdata_q, l2_wdata_d;
   logic [NUM_REQ-1:0]  req_done_q, req_done_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                flush_done_q, flush_done_d;
   logic                busy_q, busy_d;
   logic                spurious_q, spurious_d;

   logic                found_c;
   logic [ID_W-1:0]     win_id_c;
   int unsigned         scan_idx;
   logic                slot_free_c;
   logic                grant_c;
   logic                pop_c;
   logic [ID_W-1:0]     head_id_c;
   logic [NUM_REQ-1:0]  gnt_vec_c;
   logic                drained_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // First requesting port at or above rr_ptr, wrapping
   always_comb begin
      found_c  = 1'b0;
      win_id_c = '0;
      scan_idx = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = 32'(rr_ptr_q) + k;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (!found_c && req_valid[ID_W'(scan_idx)]) begin
            found_c  = 1'b1;
            win_id_c = ID_W'(scan_idx);
         end
      end
   end

   assign slot_free_c = ~l2_valid_q | ~l2_stall;
   assign pop_c       = l2_done & (count_q != '0);
   assign head_id_c   = fifo_q[rd_ptr_q];
   assign grant_c     = (state_q != ST_DRAIN) & slot_free_c &
                        ((count_q < CNT_W'(OUT_DEPTH)) | l2_done) & found_c;
   assign gnt_vec_c   = grant_c ? (NUM_REQ'(1) << win_id_c) : '0;
   assign req_stall   = req_valid & ~gnt_vec_c;

   // Datapath: output register, tag FIFO, completion routing
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      fifo_d       = fifo_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      l2_valid_d   = l2_valid_q;
      l2_rw_d      = l2_rw_q;
      l2_addr_d    = l2_addr_q;
      l2_wdata_d   = l2_wdata_q;
      req_done_d   = '0;
      resp_rdata_d = resp_rdata_q;
      spurious_d   = spurious_q | (l2_done & (count_q == '0));
      count_d      = count_q + CNT_W'(grant_c) - CNT_W'(pop_c);

      if (grant_c) begin
         rr_ptr_d           = (win_id_c == ID_W'(NUM_REQ - 1)) ? '0 : win_id_c + ID_W'(1);
         fifo_d[wr_ptr_q]   = win_id_c;
         wr_ptr_d           = ptr_inc(wr_ptr_q);
         l2_valid_d         = 1'b1;
         l2_rw_d            = req_rw[win_id_c];
         l2_addr_d          = req_addr[32'(win_id_c) * ADDR_W +: ADDR_W];
         l2_wdata_d         = req_wdata[32'(win_id_c) * DATA_W +: DATA_W];
      end else if (slot_free_c) begin
         l2_valid_d = 1'b0;
      end

      if (pop_c) begin
         rd_ptr_d     = ptr_inc(rd_ptr_q);
         req_done_d   = NUM_REQ'(1) << head_id_c;
         resp_rdata_d = l2_rdata;
      end
   end

   assign drained_c = (count_d == '0) & ~l2_valid_d;

   // Control state: flush drain sequencing
   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      busy_d       = (count_d != '0) | l2_valid_d;
      case (state_q)
         ST_IDLE: begin
            if (flush)        state_d = ST_DRAIN;
            else if (grant_c) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (flush)          state_d = ST_DRAIN;
            else if (drained_c) state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (drained_c) begin
               state_d      = ST_IDLE;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         fifo_q       <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         l2_valid_q   <= 1'b0;
         l2_rw_q      <= 1'b0;
         l2_addr_q    <= '0;
         l2_wdata_q   <= '0;
         req_done_q   <= '0;
         resp_rdata_q <= '0;
         flush_done_q <= 1'b0;
         busy_q       <= 1'b0;
         spurious_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         fifo_q       <= fifo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         l2_valid_q   <= l2_valid_d;
         l2_rw_q      <= l2_rw_d;
         l2_addr_q    <= l2_addr_d;
         l2_wdata_q   <= l2_wdata_d;
         req_done_q   <= req_done_d;
         resp_rdata_q <= resp_rdata_d;
         flush_done_q <= flush_done_d;
         busy_q       <= busy_d;
         spurious_q   <= spurious_d;
      end
   end

   assign l2_valid      = l2_valid_q;
   assign l2_rw         = l2_rw_q;
   assign l2_addr       = l2_addr_q;
   assign l2_wdata      = l2_wdata_q;
   assign req_done      = req_done_q;
   assign resp_rdata    = resp_rdata_q;
   assign flush_done    = flush_done_q;
   assign busy          = busy_q;
   assign spurious_done = spurious_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed testbench for l2_port_arbiter: per-scenario tasks with hand-computed expectations.
module tb_l2_port_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 128;

   logic                      clock = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_rw;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_stall;
   logic [NUM_REQ-1:0]        req_done;
   logic [DATA_W-1:0]         resp_rdata;
   logic                      l2_valid;
   logic                      l2_rw;
   logic [ADDR_W-1:0]         l2_addr;
   logic [DATA_W-1:0]         l2_wdata;
   logic                      l2_stall;
   logic                      l2_done;
   logic [DATA_W-1:0]         l2_rdata;
   logic                      flush;
   logic                      flush_done;
   logic                      busy;
   logic                      spurious_done;

   int total = 0;
   int bad   = 0;

   l2_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_stall(req_stall), .req_done(req_done), .resp_rdata(resp_rdata),
      .l2_valid(l2_valid), .l2_rw(l2_rw), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
      .l2_stall(l2_stall), .l2_done(l2_done), .l2_rdata(l2_rdata),
      .flush(flush), .flush_done(flush_done), .busy(busy), .spurious_done(spurious_done)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic set_cmd(input int i, input logic rw, input logic [31:0] a, input logic [127:0] d);
      req_rw[i]              = rw;
      req_addr[i*32 +: 32]   = a;
      req_wdata[i*128 +: 128] = d;
   endtask

   task automatic do_reset;
      reset     = 1'b1;
      req_valid = '0;
      l2_done   = 1'b0;
      l2_stall  = 1'b0;
      flush     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      #1;
      total++; if (l2_valid !== 1'b0) begin bad++; $display("FAIL rst_l2_valid: got %b want 0", l2_valid); end
      total++; if (l2_addr !== 32'h0) begin bad++; $display("FAIL rst_l2_addr: got %h want 0", l2_addr); end
      total++; if (req_done !== 4'b0000) begin bad++; $display("FAIL rst_req_done: got %b want 0000", req_done); end
      total++; if (resp_rdata !== 128'h0) begin bad++; $display("FAIL rst_resp: got %h want 0", resp_rdata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL rst_flush_done: got %b want 0", flush_done); end
      total++; if (spurious_done !== 1'b0) begin bad++; $display("FAIL rst_spurious: got %b want 0", spurious_done); end
      total++; if (req_stall !== 4'b0000) begin bad++; $display("FAIL rst_stall: got %b want 0000", req_stall); end
   endtask

   task automatic test_single_read;
      logic [127:0] a5 = {16{8'hA5}};
      do_reset();
      set_cmd(0, 1'b0, 32'h100, 128'h0);
      req_valid = 4'b0001;
      #1;
      total++; if (req_stall !== 4'b0000) begin bad++; $display("FAIL sr_stall: got %b want 0000", req_stall); end
      tick();
      req_valid = 4'b0000;
      #1;
      total++; if (l2_valid !== 1'b1) begin bad++; $display("FAIL sr_valid: got %b want 1", l2_valid); end
      total++; if (l2_addr !== 32'h100) begin bad++; $display("FAIL sr_addr: got %h want 100", l2_addr); end
      total++; if (l2_rw !== 1'b0) begin bad++; $display("FAIL sr_rw: got %b want 0", l2_rw); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL sr_busy: got %b want 1", busy); end
      tick();
      total++; if (l2_valid !== 1'b0) begin bad++; $display("FAIL sr_valid_drop: got %b want 0", l2_valid); end
      tick();
      tick();
      l2_done  = 1'b1;
      l2_rdata = a5;
      #1;
      total++; if (req_done !== 4'b0000) begin bad++; $display("FAIL sr_done_early: got %b want 0000", req_done); end
      tick();
      l2_done = 1'b0;
      #1;
      total++; if (req_done !== 4'b0001) begin bad++; $display("FAIL sr_done: got %b want 0001", req_done); end
      total++; if (resp_rdata !== a5) begin bad++; $display("FAIL sr_rdata: got %h want %h", resp_rdata, a5); end
      tick();
      total++; if (req_done !== 4'b0000) begin bad++; $display("FAIL sr_done_pulse: got %b want 0000", req_done); end
      total++; if (resp_rdata !== a5) begin bad++; $display("FAIL sr_rdata_hold: got %h want %h", resp_rdata, a5); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL sr_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_round_robin;
      logic [3:0]  v_in  [8] = '{4'b1111, 4'b1110, 4'b1100, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
      logic [3:0]  s_exp [8] = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic [31:0] a_exp [8] = '{32'h0, 32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h1000, 32'h0, 32'h0};
      logic [3:0]  r_exp [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [7:0]  d_bits = 8'b0111_1100;
      logic [7:0]  v_bits = 8'b0011_1110;
      logic [7:0]  b_in, b_exp;
      do_reset();
      for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 32'h1000 + 32'(i), 128'(i));
      for (int c = 0; c < 8; c++) begin
         b_in      = 8'hD0 + 8'(c);
         b_exp     = 8'hD0 + 8'(c - 1);
         req_valid = v_in[c];
         l2_done   = d_bits[c];
         l2_rdata  = {16{b_in}};
         #1;
         total++; if (req_stall !== s_exp[c]) begin bad++; $display("FAIL rr_stall c%0d: got %b want %b", c, req_stall, s_exp[c]); end
         total++; if (l2_valid !== v_bits[c]) begin bad++; $display("FAIL rr_valid c%0d: got %b want %b", c, l2_valid, v_bits[c]); end
         if (v_bits[c]) begin
            total++; if (l2_addr !== a_exp[c]) begin bad++; $display("FAIL rr_addr c%0d: got %h want %h", c, l2_addr, a_exp[c]); end
         end
         total++; if (req_done !== r_exp[c]) begin bad++; $display("FAIL rr_done c%0d: got %b want %b", c, req_done, r_exp[c]); end
         if (r_exp[c] != 4'b0000) begin
            total++; if (resp_rdata !== {16{b_exp}}) begin bad++; $display("FAIL rr_rdata c%0d: got %h want %h", c, resp_rdata, {16{b_exp}}); end
         end
         tick();
      end
      l2_done = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [3:0]  v_in  [9] = '{4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic [3:0]  s_exp [9] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic [31:0] a_exp [9] = '{32'h0, 32'h2200, 32'h2200, 32'h2200, 32'h2200, 32'h3300, 32'h0, 32'h0, 32'h0};
      logic [3:0]  r_exp [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000};
      logic [8:0]  st_bits = 9'b0_0000_1110;
      logic [8:0]  d_bits  = 9'b0_1100_0000;
      logic [8:0]  v_bits  = 9'b0_0011_1110;
      logic [127:0] w2 = {4{32'h2222_0000}};
      do_reset();
      set_cmd(2, 1'b1, 32'h2200, w2);
      set_cmd(3, 1'b0, 32'h3300, 128'h3);
      for (int c = 0; c < 9; c++) begin
         req_valid = v_in[c];
         l2_stall  = st_bits[c];
         l2_done   = d_bits[c];
         l2_rdata  = {16{8'hB0 + 8'(c)}};
         #1;
         total++; if (req_stall !== s_exp[c]) begin bad++; $display("FAIL bp_stall c%0d: got %b want %b", c, req_stall, s_exp[c]); end
         total++; if (l2_valid !== v_bits[c]) begin bad++; $display("FAIL bp_valid c%0d: got %b want %b", c, l2_valid, v_bits[c]); end
         if (v_bits[c]) begin
            total++; if (l2_addr !== a_exp[c]) begin bad++; $display("FAIL bp_addr c%0d: got %h want %h", c, l2_addr, a_exp[c]); end
         end
         if (a_exp[c] == 32'h2200) begin
            total++; if (l2_wdata !== w2) begin bad++; $display("FAIL bp_wdata c%0d: got %h want %h", c, l2_wdata, w2); end
            total++; if (l2_rw !== 1'b1) begin bad++; $display("FAIL bp_rw c%0d: got %b want 1", c, l2_rw); end
         end
         total++; if (req_done !== r_exp[c]) begin bad++; $display("FAIL bp_done c%0d: got %b want %b", c, req_done, r_exp[c]); end
         tick();
      end
      l2_done  = 1'b0;
      l2_stall = 1'b0;
   endtask

   task automatic test_fifo_full;
      logic [3:0]  v_in  [13] = '{4'b1111, 4'b1110, 4'b1100, 4'b1001, 4'b0001, 4'b0001, 4'b0001,
                                  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic [3:0]  s_exp [13] = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic [31:0] a_exp [13] = '{32'h0, 32'h4000, 32'h4010, 32'h4020, 32'h4030, 32'h0, 32'h0,
                                  32'h4400, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      logic [3:0]  r_exp [13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                  4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [12:0] d_bits = 13'b0_1111_0100_0000;
      logic [12:0] v_bits = 13'b0_0000_1001_1110;
      logic [7:0]  b_in, b_exp;
      do_reset();
      for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 32'h4000 + 32'(i * 16), 128'(i));
      for (int c = 0; c < 13; c++) begin
         if (c == 3) set_cmd(0, 1'b0, 32'h4400, 128'h44);
         b_in      = 8'hE0 + 8'(c);
         b_exp     = 8'hE0 + 8'(c - 1);
         req_valid = v_in[c];
         l2_done   = d_bits[c];
         l2_rdata  = {16{b_in}};
         #1;
         total++; if (req_stall !== s_exp[c]) begin bad++; $display("FAIL ff_stall c%0d: got %b want %b", c, req_stall, s_exp[c]); end
         total++; if (l2_valid !== v_bits[c]) begin bad++; $display("FAIL ff_valid c%0d: got %b want %b", c, l2_valid, v_bits[c]); end
         if (v_bits[c]) begin
            total++; if (l2_addr !== a_exp[c]) begin bad++; $display("FAIL ff_addr c%0d: got %h want %h", c, l2_addr, a_exp[c]); end
         end
         total++; if (req_done !== r_exp[c]) begin bad++; $display("FAIL ff_done c%0d: got %b want %b", c, req_done, r_exp[c]); end
         if (r_exp[c] != 4'b0000) begin
            total++; if (resp_rdata !== {16{b_exp}}) begin bad++; $display("FAIL ff_rdata c%0d: got %h want %h", c, resp_rdata, {16{b_exp}}); end
         end
         if (c == 5) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL ff_busy_full: got %b want 1", busy); end
         end
         if (c == 12) begin
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL ff_busy_end: got %b want 0", busy); end
         end
         tick();
      end
      l2_done = 1'b0;
   endtask

   task automatic test_flush;
      logic [3:0]  v_in  [10] = '{4'b0011, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                  4'b0000, 4'b0000, 4'b0000};
      logic [3:0]  s_exp [10] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                  4'b0000, 4'b0000, 4'b0000};
      logic [31:0] a_exp [10] = '{32'h0, 32'h5000, 32'h5010, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h5500, 32'h0, 32'h0};
      logic [3:0]  r_exp [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010,
                                  4'b0000, 4'b0000, 4'b0010};
      logic [9:0]  f_bits  = 10'b00_0011_1100;
      logic [9:0]  d_bits  = 10'b01_0011_0000;
      logic [9:0]  v_bits  = 10'b00_1000_0110;
      logic [9:0]  fd_bits = 10'b00_0100_0000;
      do_reset();
      set_cmd(0, 1'b0, 32'h5000, 128'h50);
      set_cmd(1, 1'b1, 32'h5010, 128'h51);
      for (int c = 0; c < 10; c++) begin
         if (c == 3) set_cmd(1, 1'b0, 32'h5500, 128'h55);
         req_valid = v_in[c];
         flush     = f_bits[c];
         l2_done   = d_bits[c];
         l2_rdata  = {16{8'hC0 + 8'(c)}};
         #1;
         total++; if (req_stall !== s_exp[c]) begin bad++; $display("FAIL fl_stall c%0d: got %b want %b", c, req_stall, s_exp[c]); end
         total++; if (l2_valid !== v_bits[c]) begin bad++; $display("FAIL fl_valid c%0d: got %b want %b", c, l2_valid, v_bits[c]); end
         if (v_bits[c]) begin
            total++; if (l2_addr !== a_exp[c]) begin bad++; $display("FAIL fl_addr c%0d: got %h want %h", c, l2_addr, a_exp[c]); end
         end
         total++; if (req_done !== r_exp[c]) begin bad++; $display("FAIL fl_done c%0d: got %b want %b", c, req_done, r_exp[c]); end
         total++; if (flush_done !== fd_bits[c]) begin bad++; $display("FAIL fl_flush_done c%0d: got %b want %b", c, flush_done, fd_bits[c]); end
         tick();
      end
      l2_done = 1'b0;
      flush   = 1'b0;
   endtask

   task automatic test_reset_spurious;
      do_reset();
      set_cmd(0, 1'b0, 32'h6000, 128'h60);
      set_cmd(1, 1'b0, 32'h6010, 128'h61);
      req_valid = 4'b0011;
      tick();
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0000;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      total++; if (l2_valid !== 1'b0) begin bad++; $display("FAIL rs_valid: got %b want 0", l2_valid); end
      total++; if (l2_addr !== 32'h0) begin bad++; $display("FAIL rs_addr: got %h want 0", l2_addr); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rs_busy: got %b want 0", busy); end
      total++; if (spurious_done !== 1'b0) begin bad++; $display("FAIL rs_spurious_clr: got %b want 0", spurious_done); end
      l2_done  = 1'b1;
      l2_rdata = {16{8'hFF}};
      tick();
      l2_done = 1'b0;
      #1;
      total++; if (spurious_done !== 1'b1) begin bad++; $display("FAIL rs_spurious: got %b want 1", spurious_done); end
      total++; if (req_done !== 4'b0000) begin bad++; $display("FAIL rs_req_done: got %b want 0000", req_done); end
      total++; if (resp_rdata !== 128'h0) begin bad++; $display("FAIL rs_rdata: got %h want 0", resp_rdata); end
      tick();
      total++; if (spurious_done !== 1'b1) begin bad++; $display("FAIL rs_spurious_sticky: got %b want 1", spurious_done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rs_busy_end: got %b want 0", busy); end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_rw    = '0;
      req_addr  = '0;
      req_wdata = '0;
      l2_stall  = 1'b0;
      l2_done   = 1'b0;
      l2_rdata  = '0;
      flush     = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_backpressure();
      test_fifo_full();
      test_flush();
      test_reset_spurious();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
